// File: rtl/game_pkg.sv
// Shared game types and screen geometry for the projectile, renderer and other game blocks.
// Pure declarations; no logic.
package game_pkg;

  typedef enum logic [1:0] {P_IDLE, P_FLY_R, P_FLY_L} proj_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PROJ_W   = 40;
  localparam int PROJ_H   = 10;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser plus registered edge pulse: output fires one cycle wide,
// three clocks after the input edge. FALLING selects falling (1) or rising (0) edge.
module sync_edge_det #(
  parameter bit FALLING = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_pulse;
  logic w_edge;

  assign w_edge  = FALLING ? (r_prev & ~r_sync) : (r_sync & ~r_prev);
  assign o_pulse = r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_meta  <= i_async;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_pulse <= w_edge;
    end
  end

endmodule

// File: rtl/projectile_motion_ctrl.sv
// Projectile flight FSM: launch on KEY, move one step per frame tick, reverse at screen edges.
// Optional macro PROJ_ACCEL_EN: speed grows by one (up to MAX_SPEED) on each reversal.
module projectile_motion_ctrl #(
  parameter logic [9:0] START_X     = 10'd90,
  parameter logic [9:0] START_Y     = 10'd52,
  parameter logic [9:0] X_MIN       = 10'd10,
  parameter logic [9:0] X_MAX       = 10'd639,
  parameter logic [9:0] PROJ_W      = 10'd40,
  parameter logic [3:0] SPEED       = 4'd1,
  parameter logic [3:0] MAX_SPEED   = 4'd8,
  parameter logic [7:0] MAX_BOUNCES = 8'd0
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       KEY,
  output logic [9:0] b_pos_x,
  output logic [9:0] b_pos_y,
  output logic       b_active,
  output logic       b_dir,
  output logic [7:0] bounce_cnt,
  output logic       frame_tick
);

  import game_pkg::*;

`ifdef PROJ_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  proj_state_t r_state;
  logic [9:0]  r_x;
  logic        r_dir;
  logic [7:0]  r_bounce;
  logic [3:0]  r_speed;

  logic        w_tick;
  logic        w_fire;
  logic [10:0] w_sum_r;
  logic [10:0] w_lim_l;
  logic        w_hit_r;
  logic        w_hit_l;
  logic [7:0]  w_bounce_inc;
  logic        w_done;
  logic [4:0]  w_speed_inc;
  logic [3:0]  w_speed_rev;

  sync_edge_det #(.FALLING(1'b0)) u_frame_sync (
    .i_clk   (vga_clk),
    .i_rst   (Reset),
    .i_async (frame_clk),
    .o_pulse (w_tick)
  );

  sync_edge_det #(.FALLING(1'b1)) u_key_sync (
    .i_clk   (vga_clk),
    .i_rst   (Reset),
    .i_async (KEY),
    .o_pulse (w_fire)
  );

  // 11-bit sums so the edge tests cannot wrap near the right border.
  assign w_sum_r = {1'b0, r_x} + {1'b0, PROJ_W} + {7'd0, r_speed};
  assign w_lim_l = {1'b0, X_MIN} + {7'd0, r_speed};
  assign w_hit_r = (w_sum_r >= {1'b0, X_MAX});
  assign w_hit_l = ({1'b0, r_x} <= w_lim_l);

  assign w_bounce_inc = (r_bounce == 8'hFF) ? 8'hFF : r_bounce + 8'd1;
  assign w_done       = (MAX_BOUNCES != 8'd0) && (w_bounce_inc >= MAX_BOUNCES);

  // The clamp above uses the current speed; the bumped speed takes effect next tick.
  assign w_speed_inc = {1'b0, r_speed} + 5'd1;
  assign w_speed_rev = !ACCEL ? r_speed :
                       (w_speed_inc > {1'b0, MAX_SPEED}) ? MAX_SPEED : w_speed_inc[3:0];

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_state  <= P_IDLE;
      r_x      <= START_X;
      r_dir    <= 1'b0;
      r_bounce <= 8'd0;
      r_speed  <= SPEED;
    end else begin
      case (r_state)
        P_IDLE: begin
          if (w_fire) begin
            r_state  <= P_FLY_R;
            r_x      <= START_X;
            r_dir    <= 1'b0;
            r_bounce <= 8'd0;
            r_speed  <= SPEED;
          end
        end
        P_FLY_R: begin
          if (w_tick) begin
            if (w_hit_r) begin
              r_state  <= P_FLY_L;
              r_x      <= X_MAX - PROJ_W;
              r_dir    <= 1'b1;
              r_bounce <= w_bounce_inc;
              r_speed  <= w_speed_rev;
            end else begin
              r_x <= r_x + {6'd0, r_speed};
            end
          end
        end
        P_FLY_L: begin
          if (w_tick) begin
            if (w_hit_l) begin
              r_bounce <= w_bounce_inc;
              r_speed  <= w_speed_rev;
              r_dir    <= 1'b0;
              if (w_done) begin
                r_state <= P_IDLE;
                r_x     <= START_X;
              end else begin
                r_state <= P_FLY_R;
                r_x     <= X_MIN;
              end
            end else begin
              r_x <= r_x - {6'd0, r_speed};
            end
          end
        end
        default: r_state <= P_IDLE;
      endcase
    end
  end

  assign b_pos_x    = r_x;
  assign b_pos_y    = START_Y;
  assign b_active   = (r_state != P_IDLE);
  assign b_dir      = r_dir;
  assign bounce_cnt = r_bounce;
  assign frame_tick = w_tick;

endmodule

// File: tb/tb_projectile_motion_ctrl.sv
// Bench for projectile_motion_ctrl: randomized frame gaps and key presses against a
// frame-level behavioural model of the flight.
module tb_projectile_motion_ctrl;

  logic       vga_clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       KEY;
  logic [9:0] b_pos_x;
  logic [9:0] b_pos_y;
  logic       b_active;
  logic       b_dir;
  logic [7:0] bounce_cnt;
  logic       frame_tick;

  projectile_motion_ctrl #(
    .MAX_SPEED   (4'd3),
    .MAX_BOUNCES (8'd2)
  ) dut (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .KEY        (KEY),
    .b_pos_x    (b_pos_x),
    .b_pos_y    (b_pos_y),
    .b_active   (b_active),
    .b_dir      (b_dir),
    .bounce_cnt (bounce_cnt),
    .frame_tick (frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  int ticks_seen = 0;

  // Reference model: projectile state as seen at frame granularity.
  logic m_active;
  logic m_dir;
  int   m_x;
  int   m_bounce;
  int   m_speed;

  always @(negedge vga_clk) if (frame_tick === 1'b1) ticks_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_dir = 1'b0; m_x = 90; m_bounce = 0; m_speed = 1;
  endtask

  task automatic model_fire();
    if (!m_active) begin
      m_active = 1'b1; m_dir = 1'b0; m_x = 90; m_bounce = 0; m_speed = 1;
    end
  endtask

  task automatic model_bounce();
    if (m_bounce < 255) m_bounce++;
`ifdef PROJ_ACCEL_EN
    if (m_speed < 3) m_speed++;
`endif
  endtask

  task automatic model_tick();
    if (m_active) begin
      if (!m_dir) begin
        if (m_x + 40 + m_speed >= 639) begin
          m_x = 599; m_dir = 1'b1; model_bounce();
        end else m_x = m_x + m_speed;
      end else begin
        if (m_x <= 10 + m_speed) begin
          model_bounce();
          m_dir = 1'b0;
          if (m_bounce >= 2) begin m_active = 1'b0; m_x = 90; end
          else m_x = 10;
        end else m_x = m_x - m_speed;
      end
    end
  endtask

  function automatic logic [29:0] exp_vec();
    logic [9:0] x10;
    logic [7:0] b8;
    x10 = m_x[9:0];
    b8  = m_bounce[7:0];
    return {m_active, m_dir, x10, 10'd52, b8};
  endfunction

  function automatic logic [29:0] obs_vec();
    return {b_active, b_dir, b_pos_x, b_pos_y, bounce_cnt};
  endfunction

  // One frame_clk period followed by an idle gap; the DUT has acted on the tick by return.
  task automatic do_frame(input int gap);
    frame_clk = 1'b1;
    cyc(3);
    frame_clk = 1'b0;
    cyc(3 + gap);
    model_tick();
  endtask

  task automatic press_key();
    KEY = 1'b0;
    cyc(6);
    model_fire();
    KEY = 1'b1;
    cyc(4);
  endtask

  task automatic test_reset();
    Reset = 1'b1; KEY = 1'b1; frame_clk = 1'b0;
    cyc(3);
    Reset = 1'b0;
    cyc(1);
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick);
    end
  endtask

  task automatic test_launch_held_key();
    int t0;
    int n;
    KEY = 1'b0;
    cyc(6);
    model_fire();
    t0 = ticks_seen;
    for (int i = 0; i < 10; i++) begin
      do_frame($urandom_range(0, 3));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL launch_frame%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (b_pos_x !== 10'd100 || b_active !== 1'b1 || b_dir !== 1'b0) begin
      errors++; $display("FAIL launch_x100: got x=%0d act=%b dir=%b expected x=100 act=1 dir=0",
                         b_pos_x, b_active, b_dir);
    end
    checks++;
    if (ticks_seen - t0 != 10) begin
      errors++; $display("FAIL tick_count: got %0d expected 10", ticks_seen - t0);
    end
    n = 0;
    while (m_active && n < 3000) begin
      do_frame($urandom_range(0, 2));
      n++;
      checks++;
      if (obs_vec() !== exp_vec() || b_pos_x < 10'd10 || b_pos_x > 10'd599) begin
        errors++; $display("FAIL flight_frame%0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (m_active) begin
      errors++; $display("FAIL flight_bound: model still active after %0d frames", n);
    end
    checks++;
    if (b_active !== 1'b0 || b_pos_x !== 10'd90 || bounce_cnt !== 8'd2) begin
      errors++; $display("FAIL flight_end: got act=%b x=%0d bounces=%0d expected 0/90/2",
                         b_active, b_pos_x, bounce_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      do_frame(0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL held_key_idle%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    KEY = 1'b1;
    cyc(6);
  endtask

  task automatic test_reset_midflight();
    int n;
    press_key();
    n = 0;
    while (m_x != 300 && n < 400) begin
      do_frame($urandom_range(0, 3));
      n++;
    end
    checks++;
    if (b_pos_x !== 10'd300 || b_active !== 1'b1) begin
      errors++; $display("FAIL mid_x300: got x=%0d act=%b expected x=300 act=1", b_pos_x, b_active);
    end
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    cyc(1);
    model_reset();
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_reset: got %h expected %h", obs_vec(), exp_vec());
    end
    do_frame(1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL post_reset_frame: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fire_with_tick();
    KEY = 1'b0;
    frame_clk = 1'b1;
    cyc(3);
    frame_clk = 1'b0;
    cyc(3);
    model_tick();
    model_fire();
    checks++;
    if (b_pos_x !== 10'd90 || b_active !== 1'b1) begin
      errors++; $display("FAIL same_cycle: got x=%0d act=%b expected x=90 act=1", b_pos_x, b_active);
    end
    KEY = 1'b1;
    cyc(4);
    do_frame(0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL same_cycle_next: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fire_in_flight();
    int n;
    n = 0;
    while (m_active && n < 3000) begin
      if ($urandom_range(0, 15) == 0) begin
        KEY = 1'b0;
        cyc(5);
        KEY = 1'b1;
        cyc(4);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL key_in_flight%0d: got %h expected %h", n, obs_vec(), exp_vec());
        end
      end
      do_frame($urandom_range(0, 3));
      n++;
      checks++;
      if (obs_vec() !== exp_vec() || b_pos_x < 10'd10 || b_pos_x > 10'd599) begin
        errors++; $display("FAIL rand_frame%0d: got %h expected %h", n, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (m_active || b_active !== 1'b0 || bounce_cnt !== 8'd2) begin
      errors++; $display("FAIL rand_flight_end: got act=%b bounces=%0d expected 0/2", b_active, bounce_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_launch_held_key();
    test_reset_midflight();
    test_fire_with_tick();
    test_fire_in_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
